// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : alu_rs
// Description : ALU reservation station. Holds up to DEPTH dispatched ALU
//               operations, snoops the ALU and load/store result buses to
//               capture pending source operands, and issues the lowest-index
//               entry whose two sources are ready (one issue per cycle).
// Ports       : clk, rst            - clock / asynchronous active-high reset
//               ALUen, ALU*         - dispatch request and instruction fields
//               cdbAlu*, cdbLs*     - result broadcast buses (wakeup sources)
//               rsFull              - all entries busy, dispatcher must stall
//               exEn, ex*           - issue strobe and operation to the ALU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rs #(
   parameter int                DATA_W   = 32,
   parameter int                TAG_W    = 4,
   parameter int                NAME_W   = 5,
   parameter int                OP_W     = 6,
   parameter int                DEPTH    = 8,
   parameter logic [TAG_W-1:0]  TAG_FREE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   // dispatch
   input  logic                 ALUen,
   input  logic [DATA_W-1:0]    ALUoperandO,
   input  logic [DATA_W-1:0]    ALUoperandT,
   input  logic [TAG_W-1:0]     ALUtagO,
   input  logic [TAG_W-1:0]     ALUtagT,
   input  logic [TAG_W-1:0]     ALUtagW,
   input  logic [NAME_W-1:0]    ALUnameW,
   input  logic [OP_W-1:0]      ALUop,
   input  logic [31:0]          ALUaddr,
   // result broadcast buses
   input  logic                 cdbAluEn,
   input  logic [TAG_W-1:0]     cdbAluTag,
   input  logic [DATA_W-1:0]    cdbAluData,
   input  logic                 cdbLsEn,
   input  logic [TAG_W-1:0]     cdbLsTag,
   input  logic [DATA_W-1:0]    cdbLsData,
   // status / issue
   output logic                 rsFull,
   output logic                 exEn,
   output logic [DATA_W-1:0]    exOperandO,
   output logic [DATA_W-1:0]    exOperandT,
   output logic [TAG_W-1:0]     exTagW,
   output logic [NAME_W-1:0]    exNameW,
   output logic [OP_W-1:0]      exOp,
   output logic [31:0]          exAddr
);

   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // ---------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------
   logic [DEPTH-1:0]  r_busy;
   logic [OP_W-1:0]   r_op    [DEPTH];
   logic [31:0]       r_addr  [DEPTH];
   logic [TAG_W-1:0]  r_tagW  [DEPTH];
   logic [NAME_W-1:0] r_nameW [DEPTH];
   logic [TAG_W-1:0]  r_tagO  [DEPTH];
   logic [DATA_W-1:0] r_dataO [DEPTH];
   logic [TAG_W-1:0]  r_tagT  [DEPTH];
   logic [DATA_W-1:0] r_dataT [DEPTH];

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic               w_alloc_hit;
   logic [c_IDX_W-1:0] w_alloc_idx;
   logic               w_alloc_en;
   logic               w_iss_hit;
   logic [c_IDX_W-1:0] w_iss_idx;
   logic [TAG_W-1:0]   w_in_tagO;
   logic [DATA_W-1:0]  w_in_dataO;
   logic [TAG_W-1:0]   w_in_tagT;
   logic [DATA_W-1:0]  w_in_dataT;
   logic [TAG_W-1:0]   w_wk_tagO  [DEPTH];
   logic [DATA_W-1:0]  w_wk_dataO [DEPTH];
   logic [TAG_W-1:0]   w_wk_tagT  [DEPTH];
   logic [DATA_W-1:0]  w_wk_dataT [DEPTH];

   // Snoop both result buses for one source. A bus carrying TAG_FREE is
   // ignored; the ALU bus takes priority when both carry the same tag.
   function automatic logic [TAG_W+DATA_W-1:0] f_snoop(
      input logic [TAG_W-1:0]  tag,
      input logic [DATA_W-1:0] data
   );
      if (cdbAluEn && (cdbAluTag != TAG_FREE) && (cdbAluTag == tag))
         f_snoop = {TAG_FREE, cdbAluData};
      else if (cdbLsEn && (cdbLsTag != TAG_FREE) && (cdbLsTag == tag))
         f_snoop = {TAG_FREE, cdbLsData};
      else
         f_snoop = {tag, data};
   endfunction

   assign rsFull     = &r_busy;
   assign w_alloc_en = ALUen && !rsFull && w_alloc_hit;

   // Lowest-index free slot, from registered state only: a slot freed by
   // this cycle's issue is not visible until the following cycle.
   always_comb begin
      w_alloc_hit = 1'b0;
      w_alloc_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_alloc_hit = 1'b1;
            w_alloc_idx = c_IDX_W'(i);
         end
      end
   end

   // Lowest-index busy entry with both sources ready.
   always_comb begin
      w_iss_hit = 1'b0;
      w_iss_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_busy[i] && (r_tagO[i] == TAG_FREE) && (r_tagT[i] == TAG_FREE)) begin
            w_iss_hit = 1'b1;
            w_iss_idx = c_IDX_W'(i);
         end
      end
   end

   // Bypass for the incoming dispatch and wakeup for stored entries.
   always_comb begin
      {w_in_tagO, w_in_dataO} = f_snoop(ALUtagO, ALUoperandO);
      {w_in_tagT, w_in_dataT} = f_snoop(ALUtagT, ALUoperandT);
      for (int i = 0; i < DEPTH; i++) begin
         {w_wk_tagO[i], w_wk_dataO[i]} = f_snoop(r_tagO[i], r_dataO[i]);
         {w_wk_tagT[i], w_wk_dataT[i]} = f_snoop(r_tagT[i], r_dataT[i]);
      end
   end

   // ---------------------------------------------------------------------
   // Entry update. Issue and allocation never target the same slot since
   // issue needs a busy entry and allocation a free one.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_op[i]    <= '0;
            r_addr[i]  <= '0;
            r_tagW[i]  <= TAG_FREE;
            r_nameW[i] <= '0;
            r_tagO[i]  <= TAG_FREE;
            r_dataO[i] <= '0;
            r_tagT[i]  <= TAG_FREE;
            r_dataT[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_iss_hit && (w_iss_idx == c_IDX_W'(i))) begin
               r_busy[i] <= 1'b0;
            end else if (w_alloc_en && (w_alloc_idx == c_IDX_W'(i))) begin
               r_busy[i]  <= 1'b1;
               r_op[i]    <= ALUop;
               r_addr[i]  <= ALUaddr;
               r_tagW[i]  <= ALUtagW;
               r_nameW[i] <= ALUnameW;
               r_tagO[i]  <= w_in_tagO;
               r_dataO[i] <= w_in_dataO;
               r_tagT[i]  <= w_in_tagT;
               r_dataT[i] <= w_in_dataT;
            end else if (r_busy[i]) begin
               r_tagO[i]  <= w_wk_tagO[i];
               r_dataO[i] <= w_wk_dataO[i];
               r_tagT[i]  <= w_wk_tagT[i];
               r_dataT[i] <= w_wk_dataT[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Issue outputs, forced to zero / TAG_FREE when nothing issues.
   // ---------------------------------------------------------------------
   always_comb begin
      exEn       = w_iss_hit;
      exOperandO = '0;
      exOperandT = '0;
      exTagW     = TAG_FREE;
      exNameW    = '0;
      exOp       = '0;
      exAddr     = '0;
      if (w_iss_hit) begin
         exOperandO = r_dataO[w_iss_idx];
         exOperandT = r_dataT[w_iss_idx];
         exTagW     = r_tagW[w_iss_idx];
         exNameW    = r_nameW[w_iss_idx];
         exOp       = r_op[w_iss_idx];
         exAddr     = r_addr[w_iss_idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rs
// Description : Directed self-checking bench for alu_rs (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rs;

   logic        clk = 1'b0;
   logic        rst;
   logic        ALUen;
   logic [31:0] ALUoperandO, ALUoperandT;
   logic [3:0]  ALUtagO, ALUtagT, ALUtagW;
   logic [4:0]  ALUnameW;
   logic [5:0]  ALUop;
   logic [31:0] ALUaddr;
   logic        cdbAluEn, cdbLsEn;
   logic [3:0]  cdbAluTag, cdbLsTag;
   logic [31:0] cdbAluData, cdbLsData;
   logic        rsFull, exEn;
   logic [31:0] exOperandO, exOperandT, exAddr;
   logic [3:0]  exTagW;
   logic [4:0]  exNameW;
   logic [5:0]  exOp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_rs dut (
      .clk(clk), .rst(rst),
      .ALUen(ALUen), .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
      .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW),
      .ALUnameW(ALUnameW), .ALUop(ALUop), .ALUaddr(ALUaddr),
      .cdbAluEn(cdbAluEn), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
      .cdbLsEn(cdbLsEn), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
      .rsFull(rsFull), .exEn(exEn), .exOperandO(exOperandO),
      .exOperandT(exOperandT), .exTagW(exTagW), .exNameW(exNameW),
      .exOp(exOp), .exAddr(exAddr)
   );

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ALUen = 0; ALUoperandO = 0; ALUoperandT = 0; ALUtagO = 0; ALUtagT = 0;
      ALUtagW = 0; ALUnameW = 0; ALUop = 0; ALUaddr = 0;
      cdbAluEn = 0; cdbAluTag = 0; cdbAluData = 0;
      cdbLsEn = 0; cdbLsTag = 0; cdbLsData = 0;
   endtask

   task automatic dispatch(input logic [31:0] o, input logic [31:0] t,
                           input logic [3:0] tgo, input logic [3:0] tgt,
                           input logic [3:0] tgw, input logic [4:0] nm,
                           input logic [5:0] op, input logic [31:0] ad);
      ALUen = 1; ALUoperandO = o; ALUoperandT = t; ALUtagO = tgo; ALUtagT = tgt;
      ALUtagW = tgw; ALUnameW = nm; ALUop = op; ALUaddr = ad;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick(); tick();
      n_cmp++; if (rsFull !== 1'b0) begin n_err++; $display("FAIL reset_rsFull: got %b want 0", rsFull); end
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL reset_exEn: got %b want 0", exEn); end
      n_cmp++; if ({exOperandO, exOperandT, exTagW, exAddr} !== '0) begin n_err++;
         $display("FAIL reset_exdata: got O=%h T=%h W=%h A=%h want zeros", exOperandO, exOperandT, exTagW, exAddr); end
      rst = 0;
      tick();
   endtask

   task automatic test_simple_add();
      dispatch(32'd5, 32'd7, 4'd0, 4'd0, 4'd9, 5'd3, 6'd1, 32'h100);
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL add_pre_exEn: got %b want 0", exEn); end
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1) begin n_err++; $display("FAIL add_exEn: got %b want 1", exEn); end
      n_cmp++; if (exOperandO !== 32'd5 || exOperandT !== 32'd7) begin n_err++;
         $display("FAIL add_operands: got %0d,%0d want 5,7", exOperandO, exOperandT); end
      n_cmp++; if (exTagW !== 4'd9 || exNameW !== 5'd3 || exOp !== 6'd1 || exAddr !== 32'h100) begin n_err++;
         $display("FAIL add_fields: got W=%0d N=%0d op=%0d A=%h want 9,3,1,100", exTagW, exNameW, exOp, exAddr); end
      tick();
      n_cmp++; if (exEn !== 1'b0 || exOperandO !== 32'd0 || exTagW !== 4'd0) begin n_err++;
         $display("FAIL add_after: got en=%b O=%h W=%h want 0,0,0", exEn, exOperandO, exTagW); end
   endtask

   task automatic test_ls_wakeup();
      dispatch(32'hDEAD, 32'd1, 4'd3, 4'd0, 4'd1, 5'd2, 6'd2, 32'h200);
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL lswake_wait1: got %b want 0", exEn); end
      tick();
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL lswake_wait2: got %b want 0", exEn); end
      cdbLsEn = 1; cdbLsTag = 4'd3; cdbLsData = 32'h1234;
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exOperandO !== 32'h1234 || exOperandT !== 32'd1) begin n_err++;
         $display("FAIL lswake_issue: got en=%b O=%h T=%h want 1,1234,1", exEn, exOperandO, exOperandT); end
      tick();
   endtask

   task automatic test_bypass();
      dispatch(32'd4, 32'hBAD, 4'd0, 4'd5, 4'd2, 5'd7, 6'd3, 32'h300);
      cdbAluEn = 1; cdbAluTag = 4'd5; cdbAluData = 32'd9;
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exOperandT !== 32'd9 || exOperandO !== 32'd4) begin n_err++;
         $display("FAIL bypass: got en=%b O=%h T=%h want 1,4,9", exEn, exOperandO, exOperandT); end
      tick();
   endtask

   task automatic test_free_tag_ignored();
      // A broadcast tagged TAG_FREE must not overwrite a ready operand.
      dispatch(32'd5, 32'd6, 4'd0, 4'd0, 4'd3, 5'd1, 6'd4, 32'h400);
      cdbAluEn = 1; cdbAluTag = 4'd0; cdbAluData = 32'hDEAD;
      cdbLsEn = 1; cdbLsTag = 4'd0; cdbLsData = 32'hBEEF;
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exOperandO !== 32'd5 || exOperandT !== 32'd6) begin n_err++;
         $display("FAIL freetag: got en=%b O=%h T=%h want 1,5,6", exEn, exOperandO, exOperandT); end
      tick();
   endtask

   task automatic test_dual_cdb();
      dispatch(32'd0, 32'd0, 4'd4, 4'd6, 4'd5, 5'd9, 6'd5, 32'h500);
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL dual_wait: got %b want 0", exEn); end
      cdbAluEn = 1; cdbAluTag = 4'd4; cdbAluData = 32'hAA;
      cdbLsEn = 1; cdbLsTag = 4'd6; cdbLsData = 32'hBB;
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exOperandO !== 32'hAA || exOperandT !== 32'hBB) begin n_err++;
         $display("FAIL dual_issue: got en=%b O=%h T=%h want 1,aa,bb", exEn, exOperandO, exOperandT); end
      tick();
      // same tag on both buses: ALU bus wins
      dispatch(32'd0, 32'd0, 4'd8, 4'd0, 4'd6, 5'd9, 6'd5, 32'h500);
      tick();
      idle_inputs();
      cdbAluEn = 1; cdbAluTag = 4'd8; cdbAluData = 32'h11;
      cdbLsEn = 1; cdbLsTag = 4'd8; cdbLsData = 32'h22;
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exOperandO !== 32'h11) begin n_err++;
         $display("FAIL dual_priority: got en=%b O=%h want 1,11", exEn, exOperandO); end
      tick();
   endtask

   task automatic test_back_to_back();
      dispatch(32'd1, 32'd2, 4'd0, 4'd0, 4'd10, 5'd1, 6'd6, 32'h600);
      tick();
      dispatch(32'd3, 32'd4, 4'd0, 4'd0, 4'd11, 5'd2, 6'd6, 32'h604);
      n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'd10) begin n_err++;
         $display("FAIL b2b_first: got en=%b W=%0d want 1,10", exEn, exTagW); end
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'd11 || exOperandO !== 32'd3) begin n_err++;
         $display("FAIL b2b_second: got en=%b W=%0d O=%0d want 1,11,3", exEn, exTagW, exOperandO); end
      tick();
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", exEn); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         dispatch(32'd0, 32'(i * 16), 4'd2, 4'd0, 4'(i + 1), 5'(i), 6'd7, 32'(i * 4));
         tick();
      end
      idle_inputs();
      n_cmp++; if (rsFull !== 1'b1 || exEn !== 1'b0) begin n_err++;
         $display("FAIL full_set: got full=%b en=%b want 1,0", rsFull, exEn); end
      // ninth dispatch, ready immediately; must be dropped
      dispatch(32'd1, 32'd1, 4'd0, 4'd0, 4'd15, 5'd31, 6'd7, 32'hFFC);
      tick();
      idle_inputs();
      n_cmp++; if (rsFull !== 1'b1 || exEn !== 1'b0) begin n_err++;
         $display("FAIL full_drop: got full=%b en=%b want 1,0", rsFull, exEn); end
      cdbAluEn = 1; cdbAluTag = 4'd2; cdbAluData = 32'h77;
      tick();
      idle_inputs();
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'(k + 1) || exOperandO !== 32'h77 ||
                      exOperandT !== 32'(k * 16)) begin n_err++;
            $display("FAIL full_order%0d: got en=%b W=%0d O=%h T=%h want 1,%0d,77,%h",
                     k, exEn, exTagW, exOperandO, exOperandT, k + 1, k * 16); end
         n_cmp++; if (rsFull !== (k == 0)) begin n_err++;
            $display("FAIL full_flag%0d: got %b want %b", k, rsFull, (k == 0)); end
         tick();
      end
      n_cmp++; if (exEn !== 1'b0 || rsFull !== 1'b0) begin n_err++;
         $display("FAIL full_empty: got en=%b full=%b want 0,0", exEn, rsFull); end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) begin
         dispatch(32'd0, 32'd0, 4'd7, 4'd0, 4'(i + 1), 5'd0, 6'd8, 32'd0);
         tick();
      end
      dispatch(32'd1, 32'd2, 4'd0, 4'd0, 4'd12, 5'd0, 6'd8, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (exEn !== 1'b1 || exTagW !== 4'd12) begin n_err++;
         $display("FAIL rstmid_pre: got en=%b W=%0d want 1,12", exEn, exTagW); end
      #2 rst = 1;
      #1;
      n_cmp++; if (exEn !== 1'b0 || rsFull !== 1'b0 || exTagW !== 4'd0 || exOperandO !== 32'd0) begin n_err++;
         $display("FAIL rstmid_async: got en=%b full=%b W=%0d O=%h want 0,0,0,0", exEn, rsFull, exTagW, exOperandO); end
      // activity during reset has no effect
      dispatch(32'd1, 32'd2, 4'd0, 4'd0, 4'd13, 5'd0, 6'd8, 32'd0);
      cdbAluEn = 1; cdbAluTag = 4'd7; cdbAluData = 32'h5;
      tick();
      idle_inputs();
      #2 rst = 0;
      tick();
      n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL rstmid_nodisp: got %b want 0", exEn); end
      cdbAluEn = 1; cdbAluTag = 4'd7; cdbAluData = 32'h5;
      tick();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (exEn !== 1'b0) begin n_err++; $display("FAIL rstmid_stale%0d: got %b want 0", k, exEn); end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_simple_add();
      test_ls_wakeup();
      test_bypass();
      test_free_tag_ignored();
      test_dual_cdb();
      test_back_to_back();
      test_full();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
